onehot_decoder_seq: RTL and testbench

Sequenced 3-to-8 decoder: the companion of the team's 8-to-3 priority encoder, mapping a 3-bit line index back to a one-hot 8-bit line. Codes enter through a valid/ready handshake into a small FIFO. Each code drives its one-hot output line for a programmable number of cycles, followed by a guaranteed all-zero break cycle. Used wherever an encoded index must be replayed as a timed line strobe (e.g. selecting one of eight downstream channels).

---
 rtl/onehot_decoder_seq_if.sv | 10 +
 rtl/onehot_decoder_seq.sv | 118 +++++++++++
 tb/tb_onehot_decoder_seq.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/onehot_decoder_seq_if.sv
// Code input stream for the sequenced 3-to-8 decoder: valid/ready handshake
// carrying a 3-bit line index.
interface onehot_decoder_seq_if;
  logic       in_valid;
  logic [2:0] in_code;
  logic       in_ready;

  modport master (output in_valid, output in_code, input in_ready);
  modport slave  (input in_valid, input in_code, output in_ready);
endinterface

// File: rtl/onehot_decoder_seq.sv
// Sequenced 3-to-8 decoder. Codes are queued in a small FIFO; each popped code
// drives its one-hot line for HOLD cycles, followed by one all-zero break cycle.
// en low freezes sequencing and blanks the outputs; pushes continue regardless.
module onehot_decoder_seq #(
  parameter int unsigned HOLD  = 4,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned LW = AW + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  onehot_decoder_seq_if.slave  bus,
  output logic [7:0]           y,
  output logic                 busy,
  output logic                 done,
  output logic [LW-1:0]        level
);

  typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

  localparam logic [7:0] HOLD_M1 = 8'(HOLD - 1);

  logic [2:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  state_t        state;
  logic [7:0]    cnt;
  logic [7:0]    y_reg;
  logic          done_reg;

  function automatic logic [7:0] decode(input logic [2:0] code);
    return 8'b1 << code;
  endfunction

  // Pop and push decisions are both taken from the pre-edge occupancy, so a
  // full FIFO refuses a push even when a pop happens on the same edge.
  assign full         = (count == LW'(DEPTH));
  assign empty        = (count == '0);
  assign push         = bus.in_valid && !full;
  assign pop          = en && !empty && ((state == IDLE) || (state == GAP));
  assign bus.in_ready = !full;
  assign level        = count;

  // FIFO storage; contents are don't-care after reset, only pointers matter.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_code;
  end

  // FIFO pointers and occupancy; DEPTH is a power of two so pointers wrap freely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Line sequencer: IDLE -> DRIVE for HOLD cycles -> one GAP cycle, with GAP
  // chaining straight into the next DRIVE when a code is waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      y_reg    <= '0;
      done_reg <= 1'b0;
    end else if (en) begin
      unique case (state)
        IDLE: begin
          if (pop) begin
            y_reg <= decode(mem[rd_ptr]);
            cnt   <= HOLD_M1;
            state <= DRIVE;
          end
        end
        DRIVE: begin
          if (cnt == '0) begin
            y_reg    <= '0;
            done_reg <= 1'b1;
            state    <= GAP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP: begin
          done_reg <= 1'b0;
          if (pop) begin
            y_reg <= decode(mem[rd_ptr]);
            cnt   <= HOLD_M1;
            state <= DRIVE;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign y    = en ? y_reg : 8'b0;
  assign done = en && done_reg;
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Bench for onehot_decoder_seq: a queue-based reference model tracks the
// HOLD=4 instance every cycle; hand sequences cover the corner cases and a
// second HOLD=1 instance covers the minimum-hold pattern.
module tb_onehot_decoder_seq;
  localparam int HOLD  = 4;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b1;
  logic [7:0]    y,  y2;
  logic          busy, busy2, done, done2;
  logic [LW-1:0] level, level2;

  onehot_decoder_seq_if bus ();
  onehot_decoder_seq_if bus2 ();

  onehot_decoder_seq #(.HOLD(HOLD), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .bus(bus),
    .y(y), .busy(busy), .done(done), .level(level));

  onehot_decoder_seq #(.HOLD(1), .DEPTH(DEPTH)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .bus(bus2),
    .y(y2), .busy(busy2), .done(done2), .level(level2));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: queue of codes, plus the code on display and how many
  // enabled cycles it has been shown (t == HOLD means the break cycle).
  logic [2:0] q[$];
  bit         active;
  int         cur;
  int         t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_y();
    if (en && active && t < HOLD) return 8'(1 << cur);
    return 8'h00;
  endfunction

  function automatic logic m_done();
    return en && active && (t == HOLD);
  endfunction

  task automatic model_clear();
    q.delete();
    active = 0;
    cur = 0;
    t = 0;
  endtask

  task automatic model_edge();
    int sz;
    bit do_pop;
    bit do_push;
    sz = q.size();
    do_pop = 0;
    do_push = bus.in_valid && (sz < DEPTH);
    if (en) begin
      if (!active) begin
        if (sz > 0) do_pop = 1;
      end else if (t < HOLD) begin
        t++;
      end else if (sz > 0) begin
        do_pop = 1;
      end else begin
        active = 0;
      end
    end
    if (do_pop) begin
      cur = int'(q.pop_front());
      active = 1;
      t = 0;
    end
    if (do_push) q.push_back(bus.in_code);
  endtask

  task automatic sample();
    @(negedge clk);
    chk("y", 32'(y), 32'(m_y()));
    chk("done", 32'(done), 32'(m_done()));
    chk("busy", 32'(busy), 32'(active));
    chk("level", 32'(level), 32'(q.size()));
    chk("in_ready", 32'(bus.in_ready), 32'(q.size() < DEPTH));
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cycle();
    sample();
    advance();
  endtask

  typedef struct {
    logic       en;
    logic       vld;
    logic [2:0] code;
    logic [7:0] y;
    logic       done;
    logic       busy;
    logic [2:0] level;
  } vec_t;

  vec_t vec [8];

  function automatic logic [7:0] burst_exp(input int i);
    if (i >= 2 && i <= 5)   return 8'h01;
    if (i >= 7 && i <= 10)  return 8'h80;
    if (i >= 12 && i <= 15) return 8'h08;
    return 8'h00;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int on;
    int paused;
    int dn;
    int peak;
    logic [7:0] prev;
    logic [7:0] seen[$];
    logic [7:0] exp2 [5];

    vec[0] = '{1'b1, 1'b1, 3'd5, 8'h00, 1'b0, 1'b0, 3'd0};
    vec[1] = '{1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd1};
    vec[2] = '{1'b1, 1'b0, 3'd0, 8'h20, 1'b0, 1'b1, 3'd0};
    vec[3] = '{1'b1, 1'b0, 3'd0, 8'h20, 1'b0, 1'b1, 3'd0};
    vec[4] = '{1'b1, 1'b0, 3'd0, 8'h20, 1'b0, 1'b1, 3'd0};
    vec[5] = '{1'b1, 1'b0, 3'd0, 8'h20, 1'b0, 1'b1, 3'd0};
    vec[6] = '{1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 3'd0};
    vec[7] = '{1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0};

    model_clear();
    bus.in_valid = 1'b0;  bus.in_code = 3'd0;
    bus2.in_valid = 1'b0; bus2.in_code = 3'd0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_y", 32'(y), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_level", 32'(level), 32'h0);
    chk("rst_ready", 32'(bus.in_ready), 32'h1);
    chk("rst_y2", 32'(y2), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single code 5, table-driven
    for (int i = 0; i < 8; i++) begin
      en = vec[i].en;
      bus.in_valid = vec[i].vld;
      bus.in_code = vec[i].code;
      sample();
      chk("tbl_y", 32'(y), 32'(vec[i].y));
      chk("tbl_done", 32'(done), 32'(vec[i].done));
      chk("tbl_busy", 32'(busy), 32'(vec[i].busy));
      chk("tbl_level", 32'(level), 32'(vec[i].level));
      advance();
    end

    // Burst 0,7,3
    dn = 0; peak = 0;
    for (int i = 0; i < 20; i++) begin
      bus.in_valid = (i < 3);
      bus.in_code = (i == 0) ? 3'd0 : (i == 1) ? 3'd7 : 3'd3;
      sample();
      chk("burst_y", 32'(y), 32'(burst_exp(i)));
      if (done) dn++;
      if (int'(level) > peak) peak = int'(level);
      advance();
    end
    bus.in_valid = 1'b0;
    chk("burst_peak", 32'(peak), 32'd2);
    chk("burst_dones", 32'(dn), 32'd3);

    // Fill with en low, then drain in order
    en = 1'b0;
    for (int i = 0; i <= DEPTH; i++) begin
      bus.in_valid = 1'b1;
      bus.in_code = 3'(i + 1);
      sample();
      chk("fill_ready", 32'(bus.in_ready), 32'(i < DEPTH));
      chk("fill_y", 32'(y), 32'h0);
      advance();
    end
    bus.in_valid = 1'b0;
    sample();
    chk("fill_level", 32'(level), 32'(DEPTH));
    chk("fill_ready_low", 32'(bus.in_ready), 32'h0);
    advance();
    en = 1'b1;
    prev = 8'h00;
    for (int i = 0; i < 25; i++) begin
      sample();
      if (y != 8'h00 && prev == 8'h00) seen.push_back(y);
      prev = y;
      advance();
    end
    chk("drain_count", 32'(seen.size()), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++)
      if (i < seen.size()) chk("drain_order", 32'(seen[i]), 32'(8'(1 << (i + 1))));

    // en paused mid-DRIVE of code 2
    bus.in_valid = 1'b1; bus.in_code = 3'd2;
    cycle();
    bus.in_valid = 1'b0;
    on = 0; paused = 0;
    for (int i = 0; i < 15; i++) begin
      if (on == 2 && paused < 3) begin
        en = 1'b0;
        paused++;
      end else begin
        en = 1'b1;
      end
      sample();
      if (!en) chk("pause_y", 32'(y), 32'h0);
      if (y == 8'h04) on++;
      advance();
    end
    en = 1'b1;
    chk("pause_total", 32'(on), 32'(HOLD));
    chk("pause_len", 32'(paused), 32'd3);

    // Async reset mid-DRIVE with two codes queued
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_code = (i == 0) ? 3'd6 : (i == 1) ? 3'd1 : 3'd2;
      cycle();
    end
    bus.in_valid = 1'b0;
    chk("pre_rst_y", 32'(y), 32'h40);
    chk("pre_rst_level", 32'(level), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("arst_y", 32'(y), 32'h0);
    chk("arst_level", 32'(level), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_ready", 32'(bus.in_ready), 32'h1);
    model_clear();
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      sample();
      chk("post_rst_y", 32'(y), 32'h0);
      advance();
    end

    // HOLD=1 instance: codes 1,6 back-to-back
    exp2[0] = 8'h02; exp2[1] = 8'h00; exp2[2] = 8'h40; exp2[3] = 8'h00; exp2[4] = 8'h00;
    bus2.in_valid = 1'b1; bus2.in_code = 3'd1;
    cycle();
    bus2.in_code = 3'd6;
    cycle();
    bus2.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sample();
      chk("h1_y", 32'(y2), 32'(exp2[i]));
      chk("h1_done", 32'(done2), 32'(i == 1 || i == 3));
      advance();
    end
    chk("h1_busy", 32'(busy2), 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 9) != 0);
      bus.in_valid = $urandom_range(0, 1) != 0;
      bus.in_code = 3'($urandom_range(0, 7));
      cycle();
    end
    en = 1'b1;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 30; i++) cycle();
    chk("final_level", 32'(level), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
